// File: rtl/exec_pkg.sv
// Shared constants for the execute stage: data-processing opcodes, ARM
// condition codes, NZCV bit positions and the data-processing class value.
package exec_pkg;

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8;
   localparam logic [3:0] OP_TEQ = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC;
   localparam logic [3:0] OP_MOV = 4'hD;
   localparam logic [3:0] OP_BIC = 4'hE;
   localparam logic [3:0] OP_MVN = 4'hF;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [1:0] DP_CLASS = 2'b00;

endpackage

// File: rtl/exec_alu_stage_cond_eval.sv
// Combinational ARM condition-field evaluator; shared with branch logic.
// Code 1111 (NV) never passes.
module cond_eval
   import exec_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n, z, c, v;

   assign n = nzcv[FLAG_N];
   assign z = nzcv[FLAG_Z];
   assign c = nzcv[FLAG_C];
   assign v = nzcv[FLAG_V];

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c && !z;
         COND_LS: pass = !c || z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/exec_alu_stage.sv
// Execute stage: ALU on Rn and the shifter operand, condition check against
// NZCV, registered writeback outputs and the architectural flag register.
module exec_alu_stage
   import exec_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        stall,
   input  logic [31:0] ir,
   input  logic [31:0] rn_val,
   input  logic [31:0] shifter_q,
   input  logic        shifter_c,
   output logic        out_valid,
   output logic [31:0] result,
   output logic [3:0]  rd,
   output logic        rd_we,
   output logic [3:0]  flags
);

   logic [3:0]  cond;
   logic [1:0]  iclass;
   logic [3:0]  opcode;
   logic        set_s;
   logic [3:0]  dst;
   logic        unused_ir;

   assign cond      = ir[31:28];
   assign iclass    = ir[27:26];
   assign opcode    = ir[24:21];
   assign set_s     = ir[20];
   assign dst       = ir[15:12];
   assign unused_ir = ^{ir[25], ir[19:16], ir[11:0]};

   logic cond_pass;

   cond_eval u_cond_eval (
      .cond (cond),
      .nzcv (flags),
      .pass (cond_pass)
   );

   // Every arithmetic op is x + y + cin; subtracts invert one operand so C
   // comes out as NOT borrow.
   logic [31:0] add_x, add_y;
   logic        add_cin;
   logic        is_arith;
   logic [32:0] sum;

   always_comb begin
      add_x    = rn_val;
      add_y    = shifter_q;
      add_cin  = 1'b0;
      is_arith = 1'b1;
      case (opcode)
         OP_ADD, OP_CMN: add_cin = 1'b0;
         OP_ADC:         add_cin = flags[FLAG_C];
         OP_SUB, OP_CMP: begin add_y = ~shifter_q; add_cin = 1'b1; end
         OP_SBC:         begin add_y = ~shifter_q; add_cin = flags[FLAG_C]; end
         OP_RSB:         begin add_x = shifter_q; add_y = ~rn_val; add_cin = 1'b1; end
         OP_RSC:         begin add_x = shifter_q; add_y = ~rn_val; add_cin = flags[FLAG_C]; end
         default:        is_arith = 1'b0;
      endcase
   end

   assign sum = {1'b0, add_x} + {1'b0, add_y} + {32'b0, add_cin};

   logic [31:0] alu_q;

   always_comb begin
      alu_q = sum[31:0];
      case (opcode)
         OP_AND, OP_TST: alu_q = rn_val & shifter_q;
         OP_EOR, OP_TEQ: alu_q = rn_val ^ shifter_q;
         OP_ORR:         alu_q = rn_val | shifter_q;
         OP_MOV:         alu_q = shifter_q;
         OP_BIC:         alu_q = rn_val & ~shifter_q;
         OP_MVN:         alu_q = ~shifter_q;
         default:        alu_q = sum[31:0];
      endcase
   end

   logic       is_test;
   logic       is_dp;
   logic       upd_flags;
   logic       wr_en;
   logic [3:0] nzcv_next;

   assign is_test   = opcode inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
   assign is_dp     = (iclass == DP_CLASS);
   assign upd_flags = cond_pass && is_dp && (set_s || is_test);
   assign wr_en     = cond_pass && is_dp && !is_test;

   always_comb begin
      nzcv_next         = flags;
      nzcv_next[FLAG_N] = alu_q[31];
      nzcv_next[FLAG_Z] = (alu_q == 32'h0);
      if (is_arith) begin
         nzcv_next[FLAG_C] = sum[32];
         nzcv_next[FLAG_V] = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);
      end else begin
         nzcv_next[FLAG_C] = shifter_c;
      end
   end

   // Handshake: an instruction is accepted when in_valid && !stall; stall
   // freezes every register including out_valid; an idle cycle only clears
   // out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= 32'h0;
         rd        <= 4'h0;
         rd_we     <= 1'b0;
         flags     <= 4'h0;
      end else if (!stall) begin
         out_valid <= in_valid;
         if (in_valid) begin
            result <= alu_q;
            rd     <= dst;
            rd_we  <= wr_en;
            if (upd_flags) flags <= nzcv_next;
         end
      end
   end

endmodule

// File: tb/tb_exec_alu_stage.sv
// Scoreboard bench for exec_alu_stage: a reference model predicts each
// accepted instruction's outputs and NZCV; entries are checked as they retire.
module tb_exec_alu_stage;
   import exec_pkg::*;

   localparam int W = 42;  // {res_chk, result[31:0], rd[3:0], rd_we, flags[3:0]}

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        stall;
   logic [31:0] ir;
   logic [31:0] rn_val;
   logic [31:0] shifter_q;
   logic        shifter_c;
   logic        out_valid;
   logic [31:0] result;
   logic [3:0]  rd;
   logic        rd_we;
   logic [3:0]  flags;

   exec_alu_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .stall     (stall),
      .ir        (ir),
      .rn_val    (rn_val),
      .shifter_q (shifter_q),
      .shifter_c (shifter_c),
      .out_valid (out_valid),
      .result    (result),
      .rd        (rd),
      .rd_we     (rd_we),
      .flags     (flags)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_exp;
   logic [3:0]   mflags;
   int           n_checks;
   int           n_pass;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic logic [31:0] mk_ir(input logic [3:0] c, input logic [1:0] cls,
                                         input logic [3:0] opc, input logic s,
                                         input logic [3:0] d);
      return {c, cls, 1'b0, opc, s, 4'h0, d, 12'h000};
   endfunction

   // Condition model: pairs of codes share a base test, odd codes invert it.
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, r;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      if (c == 4'hE) return 1'b1;
      if (c == 4'hF) return 1'b0;
      case (c[3:1])
         3'd0: r = z;
         3'd1: r = cy;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = cy && !z;
         3'd5: r = (n == v);
         default: r = !z && (n == v);
      endcase
      return c[0] ? !r : r;
   endfunction

   // Reference model using wide signed/unsigned arithmetic.
   task automatic predict(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                          input logic sc, output logic [W-1:0] e);
      logic [63:0] ua, ub, ur;
      longint      sa, sb, sr;
      logic [31:0] r;
      logic        cy, arith, test, ok, dp, we;
      logic [3:0]  nf, opc;
      opc = i[24:21];
      ua = {32'h0, a}; ub = {32'h0, b};
      sa = longint'($signed(a)); sb = longint'($signed(b));
      cy = 1'b0; arith = 1'b1; sr = 0; r = 32'h0;
      case (opc)
         OP_ADD, OP_CMN: begin ur = ua + ub; sr = sa + sb; cy = ur[32]; end
         OP_ADC: begin ur = ua + ub + {63'h0, mflags[1]}; sr = sa + sb + longint'(mflags[1]); cy = ur[32]; end
         OP_SUB, OP_CMP: begin cy = (ua >= ub); sr = sa - sb; end
         OP_SBC: begin cy = (ua >= ub + {63'h0, !mflags[1]}); sr = sa - sb - longint'(!mflags[1]); end
         OP_RSB: begin cy = (ub >= ua); sr = sb - sa; end
         OP_RSC: begin cy = (ub >= ua + {63'h0, !mflags[1]}); sr = sb - sa - longint'(!mflags[1]); end
         default: arith = 1'b0;
      endcase
      if (arith) r = sr[31:0];
      else begin
         case (opc)
            OP_AND, OP_TST: r = a & b;
            OP_EOR, OP_TEQ: r = a ^ b;
            OP_ORR: r = a | b;
            OP_MOV: r = b;
            OP_BIC: r = a & ~b;
            default: r = ~b;
         endcase
      end
      test = (opc >= OP_TST) && (opc <= OP_CMN);
      ok   = cond_ok(i[31:28], mflags);
      dp   = (i[27:26] == 2'b00);
      we   = ok && dp && !test;
      nf   = mflags;
      if (ok && dp && (i[20] || test)) begin
         nf[3] = r[31];
         nf[2] = (r == 32'h0);
         if (arith) begin
            nf[1] = cy;
            nf[0] = (sr > 64'sh7FFFFFFF) || (sr < -64'sh80000000);
         end else begin
            nf[1] = sc;
         end
      end
      e = {ok && dp, r, i[15:12], we, nf};
   endtask

   task automatic check_out(input string tag);
      logic [W-1:0] e;
      chk({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         last_exp = e;
         chk({tag, "_valid"}, 64'(out_valid), 64'd1);
         if (e[41]) chk({tag, "_result"}, 64'(result), 64'(e[40:9]));
         chk({tag, "_rd"}, 64'(rd), 64'(e[8:5]));
         chk({tag, "_rd_we"}, 64'(rd_we), 64'(e[4]));
         chk({tag, "_flags"}, 64'(flags), 64'(e[3:0]));
      end
   endtask

   // driver: present one instruction, accept it on the next edge, check it.
   task automatic send(input string tag, input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b, input logic c);
      logic [W-1:0] e;
      ir = i; rn_val = a; shifter_q = b; shifter_c = c;
      in_valid = 1'b1; stall = 1'b0;
      predict(i, a, b, c, e);
      exp_q.push_back(e);
      mflags = e[3:0];
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_out(tag);
   endtask

   task automatic idle_cycle(input string tag);
      in_valid = 1'b0; stall = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_rd"}, 64'(rd), 64'(last_exp[8:5]));
      chk({tag, "_rd_we"}, 64'(rd_we), 64'(last_exp[4]));
      chk({tag, "_flags"}, 64'(flags), 64'(mflags));
   endtask

   logic [31:0] edge_tab[6];

   function automatic logic [31:0] pick_operand();
      int k;
      k = $urandom_range(0, 9);
      if (k < 6) return edge_tab[k];
      return $urandom;
   endfunction

   initial begin
      n_checks = 0; n_pass = 0; mflags = 4'h0; last_exp = '0;
      edge_tab = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h5};
      rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0;
      ir = 32'h0; rn_val = 32'h0; shifter_q = 32'h0; shifter_c = 1'b0;

      #12;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_rd", 64'(rd), 64'd0);
      chk("rst_rd_we", 64'(rd_we), 64'd0);
      chk("rst_flags", 64'(flags), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      send("adds", mk_ir(COND_AL, 2'b00, OP_ADD, 1'b1, 4'd1), 32'h7FFFFFFF, 32'h1, 1'b0);
      chk("adds_lit_flags", 64'(flags), 64'b1001);
      chk("adds_lit_result", 64'(result), 64'h80000000);
      send("cmp", mk_ir(COND_AL, 2'b00, OP_CMP, 1'b0, 4'd2), 32'h5, 32'h5, 1'b0);
      chk("cmp_lit_flags", 64'(flags), 64'b0110);

      send("subs_v", mk_ir(COND_AL, 2'b00, OP_SUB, 1'b1, 4'd3), 32'h80000000, 32'h1, 1'b0);
      send("movs_set", mk_ir(COND_AL, 2'b00, OP_MOV, 1'b1, 4'd4), 32'h0, 32'h1, 1'b0);
      chk("v_only_flags", 64'(flags), 64'b0001);
      send("movs", mk_ir(COND_AL, 2'b00, OP_MOV, 1'b1, 4'd5), 32'h0, 32'hF000000F, 1'b1);
      chk("movs_lit_flags", 64'(flags), 64'b1011);

      send("cmp_z", mk_ir(COND_AL, 2'b00, OP_CMP, 1'b0, 4'd0), 32'h7, 32'h7, 1'b0);
      send("addne", mk_ir(COND_NE, 2'b00, OP_ADD, 1'b1, 4'd6), 32'h2, 32'h3, 1'b0);
      chk("addne_lit_we", 64'(rd_we), 64'd0);
      send("addseq", mk_ir(COND_EQ, 2'b00, OP_ADD, 1'b1, 4'd7), 32'h2, 32'h3, 1'b0);
      chk("addseq_lit_flags", 64'(flags), 64'b0000);

      send("cmp_c", mk_ir(COND_AL, 2'b00, OP_CMP, 1'b0, 4'd0), 32'h9, 32'h9, 1'b0);
      send("adcs", mk_ir(COND_AL, 2'b00, OP_ADC, 1'b1, 4'd8), 32'hFFFFFFFF, 32'h0, 1'b0);
      chk("adcs_lit_flags", 64'(flags), 64'b0110);
      send("sbcs", mk_ir(COND_AL, 2'b00, OP_SBC, 1'b1, 4'd9), 32'h0, 32'h0, 1'b0);
      chk("sbcs_lit_flags", 64'(flags), 64'b0110);

      send("nv", mk_ir(COND_NV, 2'b00, OP_MOV, 1'b1, 4'd10), 32'h0, 32'h0, 1'b1);
      send("non_dp", mk_ir(COND_AL, 2'b01, OP_MOV, 1'b1, 4'd11), 32'h0, 32'h0, 1'b0);
      idle_cycle("idle");

      for (int k = 0; k < 40; k++) begin
         send("rand",
              mk_ir(4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0) ? 2'b01 : 2'b00,
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15))),
              pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle_cycle("rand_idle");
      end

      // stall: inputs change, nothing moves
      send("pre_stall", mk_ir(COND_AL, 2'b00, OP_EOR, 1'b1, 4'd12), 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b1);
      for (int k = 0; k < 3; k++) begin
         stall = 1'b1; in_valid = 1'b1;
         ir = mk_ir(COND_AL, 2'b00, OP_ADD, 1'b1, 4'($urandom_range(0, 15)));
         rn_val = $urandom; shifter_q = $urandom; shifter_c = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_result", 64'(result), 64'(last_exp[40:9]));
         chk("stall_rd", 64'(rd), 64'(last_exp[8:5]));
         chk("stall_rd_we", 64'(rd_we), 64'(last_exp[4]));
         chk("stall_flags", 64'(flags), 64'(mflags));
      end

      // async reset mid-cycle while stalled with a valid instruction pending
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_result", 64'(result), 64'd0);
      chk("arst_rd", 64'(rd), 64'd0);
      chk("arst_rd_we", 64'(rd_we), 64'd0);
      chk("arst_flags", 64'(flags), 64'd0);
      mflags = 4'h0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1; stall = 1'b0; in_valid = 1'b0;
      send("post_rst", mk_ir(COND_AL, 2'b00, OP_ADD, 1'b1, 4'd13), 32'hFFFFFFFF, 32'h1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/exec_alu_stage.md
# exec_alu_stage

Execute stage downstream of the operand-2 shifter. It combines Rn with the shifter result (`shifter_q`, `shifter_c`) and evaluates the ARM condition field against the architectural NZCV register. It computes the 16 data-processing opcodes and registers the result, destination and write-enable for writeback. It owns the NZCV flag register; `flags[1]` (C) drives the shifter's carry input.

## Interface
Parameters:
- none; width fixed at 32.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `ir`/`rn_val`/`shifter_q`/`shifter_c` valid this cycle.
- `stall`  in  1  downstream not ready; hold all registered state.
- `ir`  in  32  instruction: `[31:28]` cond, `[27:26]` class, `[24:21]` opcode, `[20]` S, `[15:12]` Rd.
- `rn_val`  in  32  operand A (Rn contents).
- `shifter_q`  in  32  operand B from shifter.
- `shifter_c`  in  1  shifter carry-out.
- `out_valid`  out  1  registered outputs hold a retired instruction.
- `result`  out  32  registered ALU result.
- `rd`  out  4  registered destination register.
- `rd_we`  out  1  registered writeback enable.
- `flags`  out  4  architectural NZCV (`[3]`N `[2]`Z `[1]`C `[0]`V).

## Operation
- Accept occurs when `in_valid && !stall`. Only an accepted instruction changes state.
- The condition is evaluated against the current `flags`, before any update: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL. Code 1111 counts as fail.
- Opcodes: AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN.
  - ADC, SBC and RSC use the current `flags[1]`.
  - SUB-type carry is NOT borrow.
- Arithmetic is computed as a 33-bit sum: C = bit 32; V = operand signs equal and result sign differs (after B inversion for subtracts).
- Flag update happens only if the condition passes and (S=1 or the opcode is TST/TEQ/CMP/CMN):
  - N = `result[31]`; Z = (`result` == 0).
  - Arithmetic ops: C and V from the adder.
  - Logical ops: C = `shifter_c`; V unchanged.
- `rd_we` = 1 only if the condition passes, the class is `ir[27:26]`=00, and the opcode is not TST/TEQ/CMP/CMN.
- A condition-fail or non-data-processing instruction still retires: `out_valid`=1, `rd_we`=0, flags unchanged, `result` = computed value (don't-care).
- Cycle with no accept and no stall: `out_valid` goes to 0; other outputs keep their last values.

## Timing
- Reset (async, immediate on `rst_n` low): `out_valid`=0, `result`=0, `rd`=0, `rd_we`=0, `flags`=0000.
- Latency: 1 cycle. Outputs and `flags` update on the edge that accepts.
- Back-to-back: instruction N+1, accepted the next cycle, sees the flags written by N. No bubble is required.
- `stall`=1: every output and `flags` holds, including `out_valid`. Inputs are ignored. Upstream must hold them.
- Reset asserted during a stall or mid-stream: the in-flight instruction is discarded and no flag update occurs.
- Reset release: first accept on the first rising edge with `rst_n`=1.

## Structure
- Shared package `exec_pkg` holds:
  - opcode constants (4-bit);
  - condition codes (4-bit);
  - NZCV bit indices;
  - class constant `DP_CLASS`=2'b00.
- Sub-module `cond_eval`: combinational; inputs `cond[3:0]` and `nzcv[3:0]`, output `pass`. Reusable by branch logic.
- The top level contains the adder/logic datapath, the flag register and the output register.

## Test plan
- ADDS AL, `rn_val`=0x7FFFFFFF, `shifter_q`=1 → next cycle `result`=0x80000000, `flags`=1001, `rd_we`=1.
- CMP AL, 5 vs 5 → `result`=0, `flags`=0110, `rd_we`=0, `out_valid`=1.
- Start with `flags`=0001. MOVS, `shifter_q`=0xF000000F, `shifter_c`=1 → `flags`=1011 (V kept at 1).
- With Z=1:
  - ADDNE → `rd_we`=0, flags unchanged.
  - Next cycle, ADDSEQ 2+3 → `result`=5, `rd_we`=1, `flags`=0000.
- With C=1: ADCS 0xFFFFFFFF+0 → `result`=0, `flags`=0110. Then SBCS 0−0 with C=1 → `result`=0, `flags`=0110.
- Sequence:
  - Hold `stall`=1 for 3 cycles while inputs change → outputs and `flags` constant.
  - Pulse `rst_n` low mid-cycle → all outputs 0 immediately, before the next edge.
